// File: rtl/mult_div_unit_if.sv
// Handshake and result bus of the iterative multiply/divide unit.
// The master issues operations and MTHI/MTLO writes; the slave returns status and HI/LO.
interface mult_div_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO unit: shift-add multiply and restoring divide,
// one bit per cycle, operating on magnitudes with sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_unit_if.slave bus
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              bzero_q, bzero_d;
  logic [XLEN-1:0]   ma_q, ma_d;
  logic [XLEN-1:0]   mb_q, mb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              signed_op;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   diff;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   remv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bzero_q <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bzero_q <= bzero_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    bzero_d   = bzero_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    signed_op = ~bus.op[0];
    a_neg     = signed_op & bus.a[XLEN-1];
    b_neg     = signed_op & bus.b[XLEN-1];
    add_sum   = '0;
    rem_sh    = '0;
    diff      = '0;
    prod      = '0;
    quot      = '0;
    remv      = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.start) begin
          op_d    = bus.op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          bzero_d = (bus.b == '0);
          ma_d    = a_neg ? -bus.a : bus.a;
          mb_d    = b_neg ? -bus.b : bus.b;
          // Low half seeds the bit stream: multiplier for MULT*, dividend for DIV*.
          acc_d   = bus.op[1] ? {{XLEN{1'b0}}, (a_neg ? -bus.a : bus.a)}
                              : {{XLEN{1'b0}}, (b_neg ? -bus.b : bus.b)};
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (!op_q[1]) begin
          add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, ma_q} : '0);
          acc_d   = {add_sum, acc_q[XLEN-1:1]};
        end else begin
          rem_sh = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
          diff   = {1'b0, rem_sh} - {2'b00, mb_q};
          rem_d  = diff[XLEN+1] ? rem_sh : diff[XLEN:0];
          acc_d  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~diff[XLEN+1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) state_d = FIX;
      end

      FIX: begin
        if (!op_q[1]) begin
          prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
          hi_d = prod[2*XLEN-1:XLEN];
          lo_d = prod[XLEN-1:0];
        end else begin
          quot = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
          remv = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
          // Divide by zero: all-ones quotient regardless of signs; remainder is already a.
          lo_d = bzero_q ? '1 : quot;
          hi_d = remv;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: cycle-level arithmetic reference model,
// per-cycle compare of busy/done/hi/lo, directed literal cases and random traffic.
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mult_div_unit_if #(.XLEN(32)) bus ();

  mult_div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model state
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [63:0] m_res  = '0;
  int          m_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Returns {hi, lo} straight from the arithmetic definitions.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int              sa, sb;
    longint          la, lb;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = a; sb = b;
    la = sa; lb = sb;
    ua = {32'h0, a}; ub = {32'h0, b};
    case (op)
      2'd0: r = la * lb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
        else r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (b == 32'h0) r = {a, 32'hFFFF_FFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_cnt = 0; m_res = '0;
    end else begin
      m_done = 1'b0;
      if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_hi = m_res[63:32]; m_lo = m_res[31:0]; m_done = 1'b1;
        end
      end else begin
        if (bus.hi_we) m_hi = bus.wdata;
        if (bus.lo_we) m_lo = bus.wdata;
        if (bus.start) begin
          m_res = ref_op(bus.op, bus.a, bus.b);
          m_cnt = 33;
        end
      end
      m_busy = (m_cnt != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'b0, bus.busy}, {31'b0, m_busy});
      check("done", {31'b0, bus.done}, {31'b0, m_done});
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = 2'($urandom); bus.a = $urandom; bus.b = $urandom; bus.wdata = $urandom;
  endtask

  // Called at a negedge; issues one op, measures busy length and checks the result.
  task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo);
    int n_busy;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    n_busy = 0;
    @(negedge clk);
    idle_inputs();
    while (bus.busy && n_busy < 40) begin
      n_busy++;
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 32'(n_busy), 32'd33);
    check({name, "_done"}, {31'b0, bus.done}, 32'd1);
    check({name, "_hi"}, bus.hi, exp_hi);
    check({name, "_lo"}, bus.lo, exp_lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t actual=timeout expected=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] r;
    int          n;
    bit          saw_done;

    idle_inputs();

    r = ref_op(2'd0, 32'hFFFF_FFF9, 32'd3);
    check("model_mult_hi", r[63:32], 32'hFFFF_FFFF);
    check("model_mult_lo", r[31:0], 32'hFFFF_FFEB);
    r = ref_op(2'd2, 32'hFFFF_FFF9, 32'd2);
    check("model_div_hi", r[63:32], 32'hFFFF_FFFF);
    check("model_div_lo", r[31:0], 32'hFFFF_FFFD);

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_hi", bus.hi, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    #2 rst = 1'b1;

    do_op("mult_neg", 2'd0, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    do_op("divu_by0", 2'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    do_op("div_neg_by0", 2'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    // Start and MTHI while busy are ignored.
    bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'd5; bus.b = 32'd7;
    @(negedge clk);
    idle_inputs();
    repeat (9) @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd9; bus.b = 32'd3;
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    idle_inputs();
    n = 0;
    while (!bus.done && n < 40) begin n++; @(negedge clk); end
    check("busy_ign_done", {31'b0, bus.done}, 32'd1);
    check("busy_ign_hi", bus.hi, 32'h0);
    check("busy_ign_lo", bus.lo, 32'd35);
    bus.hi_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    idle_inputs();
    check("mthi_idle", bus.hi, 32'h1234);
    check("mthi_keep_lo", bus.lo, 32'd35);

    // Reset in the middle of a divide.
    bus.start = 1'b1; bus.op = 2'd2; bus.a = 32'd1000; bus.b = 32'd7;
    @(negedge clk);
    idle_inputs();
    repeat (14) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    saw_done = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.done) saw_done = 1'b1; end
    check("abort_no_done", {31'b0, saw_done}, 32'd0);
    #2 rst = 1'b1;
    do_op("after_rst", 2'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 2'($urandom);
      bus.a     = pick();
      bus.b     = pick();
      bus.hi_we = ($urandom_range(0, 3) == 0);
      bus.lo_we = ($urandom_range(0, 3) == 0);
      bus.wdata = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    n = 0;
    while (bus.busy && n < 40) begin n++; @(negedge clk); end
    check("final_idle", {31'b0, bus.busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
